// File: rtl/branch_sequencer_pkg.sv
// Shared pipeline definitions: branch phase codes consumed by the pipeline
// controller and the width of the redirect dwell counter.
package branch_sequencer_pkg;

  typedef enum logic [1:0] {
    BR_IDLE     = 2'b00,
    BR_REDIRECT = 2'b01,
    BR_RELEASE  = 2'b10
  } branch_status_t;

  localparam int BR_DWELL_WIDTH = 4;

endpackage

// File: rtl/branch_sequencer_perf_counter.sv
// Wrapping event counter with synchronous clear; clear wins over increment.
module perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             increment,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (increment) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Steps taken branches / JAL / JALR through REDIRECT and RELEASE phases,
// holding fetch off until the target word arrives, with jump/penalty counters.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH           = 32,
  parameter int MIN_REDIRECT_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 jump_start,
  input  logic                 want_stall,
  input  logic                 fetch_ready,
  input  logic                 abort,
  output logic [1:0]           branch_status,
  output logic                 fetch_flush,
  output logic                 seq_busy,
  output logic [CNT_WIDTH-1:0] jump_count,
  output logic [CNT_WIDTH-1:0] penalty_count
);

  localparam logic [1:0] S_IDLE     = BR_IDLE;
  localparam logic [1:0] S_REDIRECT = BR_REDIRECT;
  localparam logic [1:0] S_RELEASE  = BR_RELEASE;

  localparam logic [BR_DWELL_WIDTH-1:0] DWELL_LAST =
    BR_DWELL_WIDTH'(MIN_REDIRECT_CYCLES - 1);

  logic [1:0]                state;
  logic [1:0]                state_next;
  logic [BR_DWELL_WIDTH-1:0] dwell;
  logic [BR_DWELL_WIDTH-1:0] dwell_next;
  logic                      busy;
  logic                      accept;
  logic                      charge;

  // Abort beats stall, stall freezes everything else.
  always_comb begin
    state_next = state;
    dwell_next = dwell;
    if (abort) begin
      state_next = S_IDLE;
      dwell_next = '0;
    end else if (!want_stall) begin
      case (state)
        S_IDLE: begin
          if (jump_start) begin
            state_next = S_REDIRECT;
            dwell_next = '0;
          end
        end
        S_REDIRECT: begin
          if (dwell == DWELL_LAST && fetch_ready) begin
            state_next = S_RELEASE;
          end
          if (dwell != DWELL_LAST) begin
            dwell_next = dwell + 1'b1;
          end
        end
        S_RELEASE: state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  assign accept = (state == S_IDLE) && jump_start && !want_stall && !abort;
  assign charge = !want_stall && !abort && ((state != S_IDLE) || jump_start);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
      dwell <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      dwell <= dwell_next;
      busy  <= (state_next != S_IDLE);
    end
  end

  assign branch_status = state;
  assign seq_busy      = busy;
  assign fetch_flush   = abort || (state == S_REDIRECT);

  perf_counter #(.WIDTH(CNT_WIDTH)) u_jump_counter (
    .clock     (clock),
    .clear     (!reset),
    .increment (accept),
    .count     (jump_count)
  );

  perf_counter #(.WIDTH(CNT_WIDTH)) u_penalty_counter (
    .clock     (clock),
    .clear     (!reset),
    .increment (charge),
    .count     (penalty_count)
  );

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: three parameterisations driven by shared inputs,
// directed scenarios plus random traffic against a phase-level reference model.
module tb_branch_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic jump_start = 1'b0;
  logic want_stall = 1'b0;
  logic fetch_ready = 1'b0;
  logic abort = 1'b0;

  logic [1:0]  st1, st3, st4;
  logic        ff1, ff3, ff4;
  logic        bz1, bz3, bz4;
  logic [31:0] jc1, pc1, jc3, pc3;
  logic [3:0]  jc4, pc4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  branch_sequencer #(.CNT_WIDTH(32), .MIN_REDIRECT_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .jump_start(jump_start), .want_stall(want_stall),
    .fetch_ready(fetch_ready), .abort(abort), .branch_status(st1), .fetch_flush(ff1),
    .seq_busy(bz1), .jump_count(jc1), .penalty_count(pc1));

  branch_sequencer #(.CNT_WIDTH(32), .MIN_REDIRECT_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .jump_start(jump_start), .want_stall(want_stall),
    .fetch_ready(fetch_ready), .abort(abort), .branch_status(st3), .fetch_flush(ff3),
    .seq_busy(bz3), .jump_count(jc3), .penalty_count(pc3));

  branch_sequencer #(.CNT_WIDTH(4), .MIN_REDIRECT_CYCLES(1)) dut4 (
    .clock(clock), .reset(reset), .jump_start(jump_start), .want_stall(want_stall),
    .fetch_ready(fetch_ready), .abort(abort), .branch_status(st4), .fetch_flush(ff4),
    .seq_busy(bz4), .jump_count(jc4), .penalty_count(pc4));

  // Reference model: phase 0 idle, 1 redirect, 2 release; red counts
  // completed non-stalled redirect cycles of the current sequence.
  int ph[3], red[3], jumps[3], pen[3];
  int mins[3] = '{1, 3, 1};

  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        ph[k] <= 0; red[k] <= 0; jumps[k] <= 0; pen[k] <= 0;
      end else if (abort) begin
        ph[k] <= 0;
      end else if (!want_stall) begin
        if (ph[k] != 0 || jump_start) pen[k] <= pen[k] + 1;
        if (ph[k] == 0) begin
          if (jump_start) begin
            ph[k] <= 1; red[k] <= 0; jumps[k] <= jumps[k] + 1;
          end
        end else if (ph[k] == 1) begin
          red[k] <= red[k] + 1;
          if (red[k] + 1 >= mins[k] && fetch_ready) ph[k] <= 2;
        end else begin
          ph[k] <= 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    jump_start = 0; want_stall = 0; abort = 0; fetch_ready = 1;
    reset = 0;
    tick(); tick();
    reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (st1 !== 2'b00) begin n_fail++; $display("FAIL reset_status got %b want 00", st1); end
    n_checks++; if (ff1 !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", ff1); end
    n_checks++; if (bz1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bz1); end
    n_checks++; if (jc1 !== 32'd0 || pc1 !== 32'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", jc1, pc1); end
    // get dut3 into REDIRECT, then reset for two cycles
    jump_start = 1; tick(); jump_start = 0; tick();
    n_checks++; if (st3 !== 2'b01) begin n_fail++; $display("FAIL pre_reset_status got %b want 01", st3); end
    reset = 0; tick(); tick(); reset = 1;
    n_checks++; if (st3 !== 2'b00 || bz3 !== 1'b0 || ff3 !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs got st=%b busy=%b flush=%b want 00/0/0", st3, bz3, ff3); end
    n_checks++; if (jc3 !== 32'd0 || pc3 !== 32'd0) begin n_fail++; $display("FAIL midreset_counts got %0d/%0d want 0/0", jc3, pc3); end
    tick();
    n_checks++; if (st3 !== 2'b00) begin n_fail++; $display("FAIL midreset_no_release got %b want 00", st3); end
  endtask

  task automatic test_min_sequence();
    logic [1:0] exp_st[4] = '{2'b00, 2'b01, 2'b10, 2'b00};
    logic       exp_ff[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      jump_start = (c == 0);
      #1;
      n_checks++; if (st1 !== exp_st[c]) begin n_fail++; $display("FAIL minseq_status c%0d got %b want %b", c, st1, exp_st[c]); end
      n_checks++; if (ff1 !== exp_ff[c]) begin n_fail++; $display("FAIL minseq_flush c%0d got %b want %b", c, ff1, exp_ff[c]); end
      if (c < 3) tick();
    end
    jump_start = 0;
    n_checks++; if (jc1 !== 32'd1) begin n_fail++; $display("FAIL minseq_jumps got %0d want 1", jc1); end
    n_checks++; if (pc1 !== 32'd3) begin n_fail++; $display("FAIL minseq_penalty got %0d want 3", pc1); end
  endtask

  task automatic test_slow_fetch();
    do_reset();
    fetch_ready = 0;
    jump_start = 1; tick(); jump_start = 0;
    for (int k = 1; k <= 5; k++) begin
      fetch_ready = (k == 5);
      #1;
      n_checks++; if (st3 !== 2'b01 || ff3 !== 1'b1) begin n_fail++; $display("FAIL slow_redirect k%0d got st=%b flush=%b want 01/1", k, st3, ff3); end
      tick();
    end
    n_checks++; if (st3 !== 2'b10) begin n_fail++; $display("FAIL slow_release got %b want 10", st3); end
    tick();
    n_checks++; if (st3 !== 2'b00) begin n_fail++; $display("FAIL slow_idle got %b want 00", st3); end
    n_checks++; if (pc3 !== 32'd7 || jc3 !== 32'd1) begin n_fail++; $display("FAIL slow_counts got %0d/%0d want 1/7", jc3, pc3); end
  endtask

  task automatic test_stall();
    do_reset();
    jump_start = 1; tick(); jump_start = 0; tick();
    want_stall = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (st3 !== 2'b01 || jc3 !== 32'd1 || pc3 !== 32'd2) begin n_fail++; $display("FAIL stall_frozen k%0d got st=%b j=%0d p=%0d want 01/1/2", k, st3, jc3, pc3); end
      tick();
    end
    want_stall = 0;
    n_checks++; if (st3 !== 2'b01) begin n_fail++; $display("FAIL stall_resume1 got %b want 01", st3); end
    tick();
    n_checks++; if (st3 !== 2'b01) begin n_fail++; $display("FAIL stall_resume2 got %b want 01", st3); end
    tick();
    n_checks++; if (st3 !== 2'b10) begin n_fail++; $display("FAIL stall_release got %b want 10", st3); end
    tick();
    n_checks++; if (st3 !== 2'b00 || pc3 !== 32'd5) begin n_fail++; $display("FAIL stall_end got st=%b p=%0d want 00/5", st3, pc3); end
  endtask

  task automatic test_abort();
    do_reset();
    jump_start = 1; tick(); jump_start = 0; tick();
    abort = 1;
    #1;
    n_checks++; if (st1 !== 2'b10 || ff1 !== 1'b1) begin n_fail++; $display("FAIL abort_release got st=%b flush=%b want 10/1", st1, ff1); end
    tick(); abort = 0;
    n_checks++; if (st1 !== 2'b00 || jc1 !== 32'd1 || pc1 !== 32'd2) begin n_fail++; $display("FAIL abort_release_after got st=%b j=%0d p=%0d want 00/1/2", st1, jc1, pc1); end
    abort = 1; jump_start = 1;
    #1;
    n_checks++; if (ff1 !== 1'b1) begin n_fail++; $display("FAIL abort_start_flush got %b want 1", ff1); end
    tick(); abort = 0; jump_start = 0;
    n_checks++; if (st1 !== 2'b00 || bz1 !== 1'b0 || jc1 !== 32'd1 || pc1 !== 32'd2) begin n_fail++; $display("FAIL abort_start_after got st=%b busy=%b j=%0d p=%0d want 00/0/1/2", st1, bz1, jc1, pc1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int s = 0; s < 16; s++) begin
      jump_start = 1; tick(); jump_start = 0; tick(); tick();
      if (s == 4) begin
        n_checks++; if (jc4 !== 4'd5 || pc4 !== 4'd15) begin n_fail++; $display("FAIL b2b_mid got %0d/%0d want 5/15", jc4, pc4); end
      end
    end
    n_checks++; if (jc4 !== 4'd0 || pc4 !== 4'd0) begin n_fail++; $display("FAIL b2b_wrap got %0d/%0d want 0/0", jc4, pc4); end
    n_checks++; if (jc1 !== 32'd16 || pc1 !== 32'd48) begin n_fail++; $display("FAIL b2b_wide got %0d/%0d want 16/48", jc1, pc1); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      jump_start  = ($urandom_range(0, 99) < 40);
      want_stall  = ($urandom_range(0, 99) < 20);
      fetch_ready = ($urandom_range(0, 99) < 50);
      abort       = ($urandom_range(0, 99) < 5);
      reset       = ($urandom_range(0, 99) >= 2);
      #1;
      n_checks++;
      if (st1 !== 2'(ph[0]) || ff1 !== (abort || ph[0] == 1) || bz1 !== (ph[0] != 0) ||
          jc1 !== 32'(jumps[0]) || pc1 !== 32'(pen[0])) begin
        n_fail++;
        $display("FAIL rand_min1 c%0d got st=%b ff=%b bz=%b j=%0d p=%0d want ph=%0d j=%0d p=%0d",
                 c, st1, ff1, bz1, jc1, pc1, ph[0], jumps[0], pen[0]);
      end
      n_checks++;
      if (st3 !== 2'(ph[1]) || ff3 !== (abort || ph[1] == 1) || bz3 !== (ph[1] != 0) ||
          jc3 !== 32'(jumps[1]) || pc3 !== 32'(pen[1])) begin
        n_fail++;
        $display("FAIL rand_min3 c%0d got st=%b ff=%b bz=%b j=%0d p=%0d want ph=%0d j=%0d p=%0d",
                 c, st3, ff3, bz3, jc3, pc3, ph[1], jumps[1], pen[1]);
      end
      n_checks++;
      if (st4 !== 2'(ph[2]) || ff4 !== (abort || ph[2] == 1) || bz4 !== (ph[2] != 0) ||
          jc4 !== 4'(jumps[2]) || pc4 !== 4'(pen[2])) begin
        n_fail++;
        $display("FAIL rand_cnt4 c%0d got st=%b ff=%b bz=%b j=%0d p=%0d want ph=%0d j=%0d p=%0d",
                 c, st4, ff4, bz4, jc4, pc4, ph[2], jumps[2] % 16, pen[2] % 16);
      end
      tick();
    end
    reset = 1; abort = 0; want_stall = 0; jump_start = 0;
  endtask

  initial begin
    test_reset();
    test_min_sequence();
    test_slow_fetch();
    test_stall();
    test_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
